// File: rtl/nco_phase_disc_if.sv
// nco_phase_disc_if
//   Sample/result bundle for the CORDIC phase discriminator.
//   master : sample source / result sink (drives in_valid, sin_i, cos_i)
//   slave  : discriminator (drives in_ready and all result signals)
//   Signals:
//     in_valid, in_ready   sample handshake
//     sin_i, cos_i         signed Q / I samples, mpr bits
//     out_valid            one-enabled-cycle result strobe
//     phase_o, phi_inc_o   phase word and phase increment, apr bits
//     mag_o                unsigned magnitude, mpr+1 bits
//     zero_o               sample was (0,0)
`timescale 1ns/1ps
interface nco_phase_disc_if #(
   parameter int mpr = 16,
   parameter int apr = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic signed [mpr-1:0] sin_i;
   logic signed [mpr-1:0] cos_i;
   logic                  out_valid;
   logic [apr-1:0]        phase_o;
   logic [apr-1:0]        phi_inc_o;
   logic [mpr:0]          mag_o;
   logic                  zero_o;

   modport master (
      output in_valid, sin_i, cos_i,
      input  in_ready, out_valid, phase_o, phi_inc_o, mag_o, zero_o
   );

   modport slave (
      input  in_valid, sin_i, cos_i,
      output in_ready, out_valid, phase_o, phi_inc_o, mag_o, zero_o
   );
endinterface

// File: rtl/nco_phase_disc.sv
// nco_phase_disc
//   Recovers the NCO phase word from an I/Q sample pair with an iterative
//   CORDIC vectoring engine, plus the phase increment from the previous
//   sample (same units as the NCO increment input) and the vector magnitude.
//   One sample per iters+2 enabled cycles; result iters+1 enabled edges
//   after the accept edge.
//   Ports:
//     clk    clock
//     reset  synchronous active-high reset (priority over clken)
//     clken  clock enable; 0 freezes every register
//     bus    nco_phase_disc_if.slave: in_valid/in_ready/sin_i/cos_i in,
//            out_valid/phase_o/phi_inc_o/mag_o/zero_o out
//   Optional build macro NCO_DISC_MAG_COMP_EN: scales mag_o by the CORDIC
//   gain compensation (~0.6074) so it tracks the true |I,Q|; otherwise mag_o
//   is the raw CORDIC x (~1.6468*|I,Q|).
`timescale 1ns/1ps
module nco_phase_disc #(
   parameter int mpr   = 16,
   parameter int apr   = 32,
   parameter int iters = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clken,
   nco_phase_disc_if.slave bus
);

   // Two guard bits: negating -2^(mpr-1) and the ~1.65 CORDIC gain both fit.
   localparam int XW = mpr + 2;
   localparam int KW = $clog2(iters);
   localparam logic [KW-1:0] K_LAST = KW'(iters - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ROT  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // round(atan(2^-k) * 2^apr / (2*pi)), evaluated at elaboration only.
   function automatic logic [apr-1:0] atan_entry(input int k);
      real r;
      r = $atan(1.0 / (2.0 ** k)) * (2.0 ** apr) / (2.0 * 3.14159265358979323846);
      return apr'(longint'($floor(r + 0.5)));
   endfunction

   // Final magnitude scaling, truncated to the output width.
   function automatic logic [mpr:0] mag_scale(input logic signed [XW-1:0] x);
`ifdef NCO_DISC_MAG_COMP_EN
      return (mpr+1)'((x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9));
`else
      return (mpr+1)'(x);
`endif
   endfunction

   logic [apr-1:0] atan_tab [iters];

   for (genvar g = 0; g < iters; g++) begin : g_atan
      localparam logic [apr-1:0] AVAL = atan_entry(g);
      assign atan_tab[g] = AVAL;
   end

   logic [1:0]           state;
   logic                 accept;
   logic signed [XW-1:0] i_ext, q_ext;
   logic signed [XW-1:0] xs, ys;
   logic [apr-1:0]       phase_eff;

   logic signed [XW-1:0] x_p0, y_p0;
   logic [apr-1:0]       z_p0;
   logic [KW-1:0]        k_p0;
   logic                 zero_p0;

   logic                 first_smp;
   logic [apr-1:0]       prev_phase;
   logic                 out_valid_r;
   logic [apr-1:0]       phase_r, inc_r;
   logic [mpr:0]         mag_r;
   logic                 zero_r;

   assign accept = (state == S_IDLE) && bus.in_valid;

   always_comb begin
      i_ext     = {{2{bus.cos_i[mpr-1]}}, bus.cos_i};
      q_ext     = {{2{bus.sin_i[mpr-1]}}, bus.sin_i};
      xs        = x_p0 >>> k_p0;
      ys        = y_p0 >>> k_p0;
      // A (0,0) sample leaves y at 0 so z would drift by the whole table;
      // report phase 0 instead and let the differencer use that.
      phase_eff = zero_p0 ? '0 : z_p0;
   end

   // ---- accept / micro-rotation stage ----
   always_ff @(posedge clk) begin
      if (clken) begin
         if (accept) begin
            // Fold the left half-plane onto the right one with a 180 deg offset.
            if (i_ext[XW-1]) begin
               x_p0 <= -i_ext;
               y_p0 <= -q_ext;
               z_p0 <= {1'b1, {(apr-1){1'b0}}};
            end else begin
               x_p0 <= i_ext;
               y_p0 <= q_ext;
               z_p0 <= '0;
            end
            k_p0    <= '0;
            zero_p0 <= (bus.cos_i == '0) && (bus.sin_i == '0);
         end else if (state == S_ROT) begin
            if (!y_p0[XW-1]) begin
               x_p0 <= x_p0 + ys;
               y_p0 <= y_p0 - xs;
               z_p0 <= z_p0 + atan_tab[k_p0];
            end else begin
               x_p0 <= x_p0 - ys;
               y_p0 <= y_p0 + xs;
               z_p0 <= z_p0 - atan_tab[k_p0];
            end
            k_p0 <= k_p0 + KW'(1);
         end
      end
   end

   // ---- sequencing and result stage ----
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         out_valid_r <= 1'b0;
         phase_r     <= '0;
         inc_r       <= '0;
         mag_r       <= '0;
         zero_r      <= 1'b0;
         first_smp   <= 1'b1;
         prev_phase  <= '0;
      end else if (clken) begin
         out_valid_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.in_valid) state <= S_ROT;
            end
            S_ROT: begin
               if (k_p0 == K_LAST) state <= S_DONE;
            end
            S_DONE: begin
               phase_r     <= phase_eff;
               inc_r       <= first_smp ? '0 : phase_eff - prev_phase;
               prev_phase  <= phase_eff;
               first_smp   <= 1'b0;
               mag_r       <= mag_scale(x_p0);
               zero_r      <= zero_p0;
               out_valid_r <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.phase_o   = phase_r;
   assign bus.phi_inc_o = inc_r;
   assign bus.mag_o     = mag_r;
   assign bus.zero_o    = zero_r;

endmodule

// File: tb/tb_nco_phase_disc.sv
// tb_nco_phase_disc
//   Scoreboard bench for nco_phase_disc: expected phase / increment / zero /
//   magnitude are pushed at each accept from a floating-point model and
//   popped when the DUT strobes out_valid. Scenario tasks add latency,
//   handshake, stall and reset checks.
`timescale 1ns/1ps
module tb_nco_phase_disc;

   localparam int  MPR     = 16;
   localparam int  APR     = 32;
   localparam int  ITERS   = 16;
   localparam real PI      = 3.14159265358979323846;
   localparam real KGAIN   = 1.6467602581;
   localparam int  PH_TOL  = 1 << 17;
   localparam int  INC_TOL = 1 << 18;
   localparam int  MAG_TOL = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic clken = 1'b1;

   nco_phase_disc_if #(.mpr(MPR), .apr(APR)) bus ();

   nco_phase_disc #(.mpr(MPR), .apr(APR), .iters(ITERS)) dut (
      .clk   (clk),
      .reset (reset),
      .clken (clken),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] phase;
      logic [31:0] inc;
      logic        first;
      logic        zero;
      int          mag;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic        en_q = 1'b0;
   int          n_res = 0;
   int          last_out_cyc = 0;
   logic [31:0] last_phase = '0;
   logic [31:0] last_inc = '0;
   logic [31:0] mdl_prev = '0;
   logic        mdl_first = 1'b1;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      en_q <= clken;
   end

   function automatic int unsigned mdist(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      d = a - b;
      return d[31] ? -d : d;
   endfunction

   function automatic logic [31:0] exp_phase(input int c, input int s);
      real a;
      a = $atan2(real'(s), real'(c));
      if (a < 0.0) a = a + 2.0 * PI;
      return 32'(longint'($floor(a / (2.0 * PI) * 4294967296.0 + 0.5)));
   endfunction

   function automatic int exp_mag(input int c, input int s);
      real m;
      m = $sqrt(real'(c) * c + real'(s) * s);
`ifndef NCO_DISC_MAG_COMP_EN
      m = m * KGAIN;
`endif
      return int'($floor(m + 0.5));
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic push(input int c, input int s);
      exp_t e;
      e.zero    = (c == 0) && (s == 0);
      e.phase   = e.zero ? 32'h0 : exp_phase(c, s);
      e.first   = mdl_first;
      e.inc     = mdl_first ? 32'h0 : e.phase - mdl_prev;
      e.mag     = exp_mag(c, s);
      mdl_prev  = e.phase;
      mdl_first = 1'b0;
      sb.push_back(e);
   endtask

   // Result monitor: a high out_valid after an enabled edge is a fresh result.
   always @(negedge clk) begin
      if (bus.out_valid && en_q) begin
         n_res        = n_res + 1;
         last_out_cyc = cyc;
         last_phase   = bus.phase_o;
         last_inc     = bus.phi_inc_o;
         if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_result phase=%h (no sample pending)", bus.phase_o);
         end else begin
            mon_e = sb.pop_front();
            n_cmp++;
            if (bus.zero_o !== mon_e.zero) begin
               n_fail++;
               $display("FAIL zero_o got=%b want=%b", bus.zero_o, mon_e.zero);
            end
            n_cmp++;
            if (mon_e.zero ? (bus.phase_o !== 32'h0) : (mdist(bus.phase_o, mon_e.phase) > PH_TOL)) begin
               n_fail++;
               $display("FAIL phase_o got=%h want=%h", bus.phase_o, mon_e.phase);
            end
            n_cmp++;
            if (mon_e.first ? (bus.phi_inc_o !== 32'h0) : (mdist(bus.phi_inc_o, mon_e.inc) > INC_TOL)) begin
               n_fail++;
               $display("FAIL phi_inc_o got=%h want=%h", bus.phi_inc_o, mon_e.inc);
            end
            n_cmp++;
            if (iabs(int'(bus.mag_o) - mon_e.mag) > MAG_TOL) begin
               n_fail++;
               $display("FAIL mag_o got=%0d want=%0d", bus.mag_o, mon_e.mag);
            end
         end
      end
   end

   // Present a sample and return just after the edge that accepts it.
   task automatic send(input int c, input int s, input bit hold, output int acc);
      int g;
      @(negedge clk);
      bus.cos_i    = 16'(c);
      bus.sin_i    = 16'(s);
      bus.in_valid = 1'b1;
      g = 0;
      while (!(bus.in_ready && clken) && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) begin
         n_cmp++; n_fail++;
         $display("FAIL accept_timeout in_ready=%b want=1", bus.in_ready);
      end
      @(posedge clk);
      push(c, s);
      #1;
      acc = cyc;
      if (!hold) bus.in_valid = 1'b0;
   endtask

   task automatic wait_res(input int target);
      int g;
      g = 0;
      while (n_res < target && g < 200) begin
         @(negedge clk);
         #1;
         g++;
      end
      if (n_res < target) begin
         n_cmp++; n_fail++;
         $display("FAIL result_timeout got=%0d want=%0d", n_res, target);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
      n_cmp++; if (bus.phase_o !== 32'h0)   begin n_fail++; $display("FAIL rst_phase got=%h want=0", bus.phase_o); end
      n_cmp++; if (bus.phi_inc_o !== 32'h0) begin n_fail++; $display("FAIL rst_inc got=%h want=0", bus.phi_inc_o); end
      n_cmp++; if (bus.mag_o !== 17'h0)     begin n_fail++; $display("FAIL rst_mag got=%h want=0", bus.mag_o); end
      n_cmp++; if (bus.zero_o !== 1'b0)     begin n_fail++; $display("FAIL rst_zero got=%b want=0", bus.zero_o); end
      reset = 1'b0;
      sb.delete();
      mdl_first = 1'b1;
      mdl_prev  = '0;
   endtask

   task automatic test_first_sample();
      int acc;
      int base;
      base = n_res;
      send(16384, 0, 1'b0, acc);
      wait_res(base + 1);
      n_cmp++;
      if (last_out_cyc - acc !== ITERS + 1) begin
         n_fail++;
         $display("FAIL latency got=%0d want=%0d", last_out_cyc - acc, ITERS + 1);
      end
   endtask

   task automatic test_quadrants();
      int acc;
      int cs [4] = '{0, -16384, 0, -32768};
      int ss [4] = '{16384, 0, -16384, 0};
      for (int i = 0; i < 4; i++) begin
         int base;
         base = n_res;
         send(cs[i], ss[i], 1'b0, acc);
         wait_res(base + 1);
      end
      n_cmp++;
      if (mdist(last_phase, 32'h8000_0000) > PH_TOL) begin
         n_fail++;
         $display("FAIL neg_fullscale_phase got=%h want=80000000", last_phase);
      end
   endtask

   task automatic test_rotating();
      int acc;
      for (int i = 0; i < 10; i++) begin
         real a;
         int  base;
         a = (22.5 + 45.0 * i) * PI / 180.0;
         base = n_res;
         send(int'($floor(20000.0 * $cos(a) + 0.5)), int'($floor(20000.0 * $sin(a) + 0.5)), 1'b0, acc);
         wait_res(base + 1);
         if (i > 0) begin
            n_cmp++;
            if (mdist(last_inc, 32'h2000_0000) > INC_TOL) begin
               n_fail++;
               $display("FAIL rot_inc step=%0d got=%h want=20000000", i, last_inc);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc [6];
      int base;
      base = n_res;
      for (int i = 0; i < 6; i++) begin
         real a;
         a = (10.0 + 30.0 * i) * PI / 180.0;
         send(int'($floor(12000.0 * $cos(a) + 0.5)), int'($floor(12000.0 * $sin(a) + 0.5)), 1'b1, acc[i]);
         if (i == 0) begin
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_busy_in_ready got=%b want=0", bus.in_ready);
            end
         end
      end
      bus.in_valid = 1'b0;
      for (int i = 1; i < 6; i++) begin
         n_cmp++;
         if (acc[i] - acc[i-1] !== ITERS + 2) begin
            n_fail++;
            $display("FAIL b2b_interval idx=%0d got=%0d want=%0d", i, acc[i] - acc[i-1], ITERS + 2);
         end
      end
      wait_res(base + 6);
      repeat (4) @(negedge clk);
      n_cmp++;
      if (n_res !== base + 6) begin
         n_fail++;
         $display("FAIL b2b_count got=%0d want=%0d", n_res - base, 6);
      end
   endtask

   task automatic test_stall();
      int acc;
      int base;
      base = n_res;
      send(-7000, 11000, 1'b0, acc);
      wait_res(base + 1);
      send(-7000, 11000, 1'b0, acc);
      repeat (4) @(negedge clk);
      clken = 1'b0;
      repeat (5) @(negedge clk);
      clken = 1'b1;
      wait_res(base + 2);
      n_cmp++;
      if (last_out_cyc - acc !== ITERS + 1 + 5) begin
         n_fail++;
         $display("FAIL stall_latency got=%0d want=%0d", last_out_cyc - acc, ITERS + 6);
      end
      n_cmp++;
      if (last_inc !== 32'h0) begin
         n_fail++;
         $display("FAIL stall_repeat_inc got=%h want=0", last_inc);
      end
      clken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL out_valid_hold cyc=%0d got=%b want=1", i, bus.out_valid);
         end
      end
      clken = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL out_valid_clear got=%b want=0", bus.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      int acc;
      int base;
      send(9000, -4000, 1'b0, acc);
      repeat (7) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
      reset = 1'b0;
      sb.delete();
      mdl_first = 1'b1;
      mdl_prev  = '0;
      base = n_res;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (n_res !== base) begin
         n_fail++;
         $display("FAIL midrst_spurious got=%0d want=0", n_res - base);
      end
      send(0, 0, 1'b0, acc);
      wait_res(base + 1);
      n_cmp++;
      if (last_inc !== 32'h0) begin
         n_fail++;
         $display("FAIL midrst_first_inc got=%h want=0", last_inc);
      end
      send(0, 16384, 1'b0, acc);
      wait_res(base + 2);
      send(0, 0, 1'b0, acc);
      wait_res(base + 3);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.cos_i    = '0;
      bus.sin_i    = '0;
      test_reset();
      test_first_sample();
      test_quadrants();
      test_rotating();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      repeat (5) @(negedge clk);
      n_cmp++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog n_res=%0d pending=%0d", n_res, sb.size());
      $fatal(1, "watchdog expired");
   end

endmodule
